// File: rtl/arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, owner id,
// funct3 access-mode encodings and the latched access record.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef logic owner_t;

    localparam owner_t OWNER_M0 = 1'b0;
    localparam owner_t OWNER_M1 = 1'b1;

    localparam logic [2:0] MODE_LB  = 3'b000;
    localparam logic [2:0] MODE_LH  = 3'b001;
    localparam logic [2:0] MODE_LW  = 3'b010;
    localparam logic [2:0] MODE_LBU = 3'b100;
    localparam logic [2:0] MODE_LHU = 3'b101;
    localparam logic [2:0] MODE_SB  = 3'b000;
    localparam logic [2:0] MODE_SH  = 3'b001;
    localparam logic [2:0] MODE_SW  = 3'b010;

    typedef struct packed {
        logic        we;
        logic [2:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    function automatic acc_t make_acc(input logic we, input logic [2:0] mode,
                                      input logic [31:0] addr, input logic [31:0] wdata);
        acc_t a;
        a.we    = we;
        a.mode  = mode;
        a.addr  = addr;
        a.wdata = wdata;
        return a;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector: a lone requester wins, and on a
// tie the master that was not served last wins.
module rr_pick2
    import arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    output owner_t     grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = OWNER_M0;
        unique case (req_i)
            2'b10:   grant_o = OWNER_M1;
            2'b11:   grant_o = ~last_i;
            default: grant_o = OWNER_M0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter: grants one access at a time to a single slave,
// waits for the slave ack (or a timeout) and returns a one-cycle ack to the owner.
module dmem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_mode,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_mode,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    output logic        s_we,
    output logic [2:0]  s_mode,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    input  logic [31:0] s_rdata
);

    // Counter holds the number of ack-less WAIT cycles already spent; the
    // TIMEOUT-th such cycle is the last one s_req stays high.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    owner_t      owner_q, owner_d;
    owner_t      last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    acc_t        acc_q, acc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    owner_t      pick_id;
    logic        pick_valid;

    rr_pick2 u_pick (
        .req_i   ({m1_req, m0_req}),
        .last_i  (last_q),
        .grant_o (pick_id),
        .valid_o (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWNER_M0;
            last_q  <= OWNER_M1;
            cnt_q   <= '0;
            acc_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_id;
                    last_d  = pick_id;
                    cnt_d   = '0;
                    acc_d   = (pick_id == OWNER_M1)
                            ? make_acc(m1_we, m1_mode, m1_addr, m1_wdata)
                            : make_acc(m0_we, m0_mode, m0_addr, m0_wdata);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A late ack on the final cycle still wins over the timeout.
                if (s_ack) begin
                    rdata_d = s_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic resp_m0, resp_m1;

    assign resp_m0  = (state_q == RESP) && (owner_q == OWNER_M0);
    assign resp_m1  = (state_q == RESP) && (owner_q == OWNER_M1);

    assign m0_ack   = resp_m0;
    assign m0_err   = resp_m0 & err_q;
    assign m0_rdata = resp_m0 ? rdata_q : '0;
    assign m1_ack   = resp_m1;
    assign m1_err   = resp_m1 & err_q;
    assign m1_rdata = resp_m1 ? rdata_q : '0;

    assign s_req    = (state_q == WAIT);
    assign s_we     = s_req & acc_q.we;
    assign s_mode   = s_req ? acc_q.mode  : '0;
    assign s_addr   = s_req ? acc_q.addr  : '0;
    assign s_wdata  = s_req ? acc_q.wdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: scripted masters and slave, with a
// scoreboard of expected completions checked whenever an ack appears.
module tb_dmem_arbiter;
    import arb_pkg::*;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [2:0]  m0_mode, m1_mode;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack;
    logic [2:0]  s_mode;
    logic [31:0] s_addr, s_wdata, s_rdata;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    dmem_arbiter #(.TIMEOUT(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_mode  (m0_mode),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_mode  (m1_mode),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .s_req    (s_req),
        .s_we     (s_we),
        .s_mode   (s_mode),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .s_rdata  (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completion monitor: every ack must match the oldest expected completion.
    always @(negedge clk) begin
        if (m0_ack || m1_ack) begin
            exp_t e;
            logic        id;
            logic [31:0] rd, other_rd;
            logic        er;
            checks++;
            if (m0_ack && m1_ack) begin
                errors++;
                $display("FAIL dual_ack: m0_ack=%0b m1_ack=%0b, required only one", m0_ack, m1_ack);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: m%0d ack with empty scoreboard, required no ack", m1_ack);
            end else begin
                e        = sb.pop_front();
                id       = m1_ack;
                rd       = id ? m1_rdata : m0_rdata;
                er       = id ? m1_err : m0_err;
                other_rd = id ? m0_rdata : m1_rdata;
                $display("txn ack m%0d rdata=%08h err=%0b", id, rd, er);
                if (id !== e.id || rd !== e.rdata || er !== e.err || other_rd !== 32'h0) begin
                    errors++;
                    $display("FAIL sb_ack: got m%0d rdata=%08h err=%0b other_rdata=%08h, required m%0d rdata=%08h err=%0b other_rdata=0",
                             id, rd, er, other_rd, e.id, e.rdata, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        s_ack  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Slave holds off for 'delay' cycles after the current WAIT cycle, then acks.
    task automatic slave_ack(input int delay, input logic [31:0] data);
        repeat (delay) tick();
        s_ack   = 1'b1;
        s_rdata = data;
        tick();
        s_ack   = 1'b0;
        s_rdata = 32'h0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({m0_ack, m1_ack, m0_err, m1_err, s_req, s_we} !== 6'b0 ||
            m0_rdata !== 32'h0 || m1_rdata !== 32'h0 ||
            s_mode !== 3'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: acks=%0b%0b errs=%0b%0b s_req=%0b s_addr=%08h s_wdata=%08h, required all 0",
                     m0_ack, m1_ack, m0_err, m1_err, s_req, s_addr, s_wdata);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: s_req=%0b, required 0", s_req);
        end
    endtask

    task automatic test_single_load;
        m0_req = 1'b1; m0_we = 1'b0; m0_mode = MODE_LW; m0_addr = 32'h100; m0_wdata = 32'h0;
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h100 || s_we !== 1'b0 || s_mode !== MODE_LW) begin
            errors++;
            $display("FAIL load_sreq: s_req=%0b s_addr=%08h s_we=%0b s_mode=%0d, required 1 00000100 0 2",
                     s_req, s_addr, s_we, s_mode);
        end
        sb.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        slave_ack(2, 32'hDEADBEEF);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'hDEADBEEF || m0_err !== 1'b0) begin
            errors++;
            $display("FAIL load_ack: m0_ack=%0b m1_ack=%0b m0_rdata=%08h m0_err=%0b, required 1 0 deadbeef 0",
                     m0_ack, m1_ack, m0_rdata, m0_err);
        end
        m0_req = 1'b0;
        tick();
        checks++;
        if (m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL load_ack_pulse: m0_ack=%0b one cycle later, required 0", m0_ack);
        end
    endtask

    task automatic test_round_robin;
        logic first_tab [3];
        logic w;
        logic [31:0] data;
        first_tab[0] = 1'b0;
        first_tab[1] = 1'b0;
        first_tab[2] = 1'b1;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            if (r == 2) begin
                // A lone m0 access moves the pointer so the next tie goes to m1.
                m0_req = 1'b1; m0_addr = 32'h30;
                tick();
                sb.push_back('{1'b0, 32'h3333_0000, 1'b0});
                slave_ack(0, 32'h3333_0000);
                m0_req = 1'b0;
                tick();
            end
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10 + r;
            m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20 + r;
            for (int k = 0; k < 2; k++) begin
                w    = (k == 0) ? first_tab[r] : ~first_tab[r];
                data = 32'hA000_0000 | (r << 4) | k;
                tick();
                checks++;
                if (s_req !== 1'b1 || s_addr !== (w ? 32'h20 + r : 32'h10 + r)) begin
                    errors++;
                    $display("FAIL rr_order: round %0d slot %0d s_req=%0b s_addr=%08h, required 1 and master %0d address",
                             r, k, s_req, s_addr, w);
                end
                sb.push_back('{w, data, 1'b0});
                slave_ack(1, data);
                if (w) m1_req = 1'b0;
                else   m0_req = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_timeout;
        int n;
        m1_req = 1'b1; m1_we = 1'b1; m1_mode = MODE_SW; m1_addr = 32'h200; m1_wdata = 32'h12345678;
        tick();
        checks++;
        if (s_we !== 1'b1 || s_wdata !== 32'h12345678 || s_mode !== MODE_SW || s_addr !== 32'h200) begin
            errors++;
            $display("FAIL store_fields: s_we=%0b s_wdata=%08h s_mode=%0d s_addr=%08h, required 1 12345678 2 00000200",
                     s_we, s_wdata, s_mode, s_addr);
        end
        sb.push_back('{1'b1, 32'h0, 1'b1});
        n = 0;
        while (s_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL timeout_len: s_req high for %0d cycles, required 15", n);
        end
        checks++;
        if (m1_ack !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0 || s_addr !== 32'h0 || s_we !== 1'b0) begin
            errors++;
            $display("FAIL timeout_resp: m1_ack=%0b m1_err=%0b m1_rdata=%08h s_addr=%08h s_we=%0b, required 1 1 0 0 0",
                     m1_ack, m1_err, m1_rdata, s_addr, s_we);
        end
        // A stray slave ack in RESP and IDLE must change nothing.
        m1_req  = 1'b0;
        s_ack   = 1'b1;
        s_rdata = 32'h5555_5555;
        tick();
        tick();
        checks++;
        if (s_req !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: s_req=%0b m0_ack=%0b m1_ack=%0b, required 0 0 0", s_req, m0_ack, m1_ack);
        end
        s_ack   = 1'b0;
        s_rdata = 32'h0;
        tick();
    endtask

    task automatic test_ack_at_timeout;
        m0_req = 1'b1; m0_we = 1'b0; m0_mode = MODE_LHU; m0_addr = 32'h300;
        tick();
        repeat (14) tick();
        checks++;
        if (s_req !== 1'b1) begin
            errors++;
            $display("FAIL last_wait_cycle: s_req=%0b on WAIT cycle 15, required 1", s_req);
        end
        sb.push_back('{1'b0, 32'hCAFEF00D, 1'b0});
        slave_ack(0, 32'hCAFEF00D);
        checks++;
        if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL ack_at_timeout: m0_ack=%0b m0_err=%0b m0_rdata=%08h, required 1 0 cafef00d",
                     m0_ack, m0_err, m0_rdata);
        end
        m0_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait;
        int acks;
        m0_req = 1'b1; m0_we = 1'b0; m0_mode = MODE_LB; m0_addr = 32'h3F0;
        tick();
        tick();
        reset  = 1'b1;
        m0_req = 1'b0;
        tick();
        reset  = 1'b0;
        checks++;
        if (s_req !== 1'b0 || s_addr !== 32'h0 || m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: s_req=%0b s_addr=%08h m0_ack=%0b, required 0 0 0", s_req, s_addr, m0_ack);
        end
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m0_ack || m1_ack || s_req) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++;
            $display("FAIL reset_no_ack: %0d cycles with ack or s_req after abort, required 0", acks);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        m0_req = 1'b1; m0_we = 1'b1; m0_mode = MODE_SB; m0_addr = 32'h400; m0_wdata = 32'h0000_00AA;
        tick();
        sb.push_back('{1'b0, 32'h1111_2222, 1'b0});
        m1_req = 1'b1; m1_we = 1'b0; m1_mode = MODE_LH; m1_addr = 32'h500;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (s_addr !== 32'h400 || s_wdata !== 32'h0000_00AA || s_we !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad !== 0 || s_addr !== 32'h400) begin
            errors++;
            $display("FAIL pending_stable: %0d unstable cycles, s_addr=%08h, required 0 and 00000400", bad, s_addr);
        end
        slave_ack(0, 32'h1111_2222);
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL pending_owner: m0_ack=%0b m1_ack=%0b, required 1 0", m0_ack, m1_ack);
        end
        m0_req = 1'b0;
        tick();
        checks++;
        if (s_req !== 1'b0) begin
            errors++;
            $display("FAIL pending_idle: s_req=%0b in IDLE, required 0", s_req);
        end
        tick();
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h500 || s_we !== 1'b0) begin
            errors++;
            $display("FAIL pending_grant: s_req=%0b s_addr=%08h s_we=%0b, required 1 00000500 0", s_req, s_addr, s_we);
        end
        sb.push_back('{1'b1, 32'h0000_BEEF, 1'b0});
        slave_ack(1, 32'h0000_BEEF);
        checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL pending_ack: m1_ack=%0b m1_rdata=%08h, required 1 0000beef", m1_ack, m1_rdata);
        end
        m1_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_mode = 3'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_mode = 3'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_ack  = 1'b0; s_rdata = 32'h0;

        test_reset();
        test_single_load();
        test_round_robin();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid_wait();
        test_back_to_back();

        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected completions never seen, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, max cycles to wait for slave ack before error-completion (1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 m0_req, m1_req  input  1 each  request; master 0 = core data port, master 1 = loader/debug.
REQ-005 m0_we, m1_we  input  1 each  1 = store, 0 = load.
REQ-006 m0_mode, m1_mode  input  3 each  access mode, funct3 encoding.
REQ-007 m0_addr, m1_addr, m0_wdata, m1_wdata  input  32 each  byte address, store data.
REQ-008 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-009 m0_err, m1_err  output  1 each  timeout flag, valid only with ack.
REQ-010 m0_rdata, m1_rdata  output  32 each  load data, valid only with ack.
REQ-011 s_req  output  1  slave request, held until s_ack or timeout.
REQ-012 s_we, s_mode, s_addr, s_wdata  output  1/3/32/32  latched request fields to slave.
REQ-013 s_ack  input  1  slave completion; s_rdata input 32, valid with s_ack.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP; reset state IDLE.
REQ-015 IDLE: no req -> stay IDLE; any req -> latch winner's we/mode/addr/wdata and owner id, go WAIT next cycle.
REQ-016 Arbitration SHALL be two-way round-robin: single requester wins; both requesting -> master not served last wins; after reset master 0 has priority.
REQ-017 Round-robin pointer SHALL update only on grant (IDLE->WAIT), not on completion.
REQ-018 WAIT: s_req=1 with latched fields stable every cycle; s_ack=1 -> capture s_rdata, err=0, go RESP.
REQ-019 WAIT timeout counter SHALL clear on WAIT entry and increment each WAIT cycle without s_ack; reaching TIMEOUT -> s_req drops, rdata=0, err=1, go RESP.
REQ-020 s_ack in the same cycle the counter reaches TIMEOUT SHALL be treated as normal completion (err=0).
REQ-021 s_ack outside WAIT SHALL be ignored.
REQ-022 RESP: owner's ack=1 for exactly one cycle with captured rdata/err; other master's ack/err=0, rdata=0; go IDLE next cycle.
REQ-023 Latency: req sampled in IDLE at cycle N -> s_req at N+1; s_ack at cycle M -> master ack at M+1; minimum req-to-ack 3 cycles.
REQ-024 Masters SHALL hold req and fields stable until ack and drop req the cycle after ack; arbiter does not re-sample fields after grant.
REQ-025 Request from a non-owner during WAIT/RESP SHALL be held pending and arbitrated in next IDLE.
REQ-026 rdata SHALL be passed unmodified; mode-based extension belongs to the slave.
REQ-027 s_we, s_mode, s_addr, s_wdata SHALL be 0 whenever s_req=0.

Reset
REQ-028 Reset asserted in any state SHALL force IDLE next cycle, aborting any access without ack.
REQ-029 Reset values: all outputs 0, pointer = master 0 priority, counter 0, latched fields 0.

Structure
REQ-030 Shared package arb_pkg: FSM state enum, owner id type, funct3 mode constants (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-031 One sub-module rr_pick2: combinational 2-way round-robin selector (req[1:0], last -> grant id, valid).

Verification
REQ-032 m0 load addr 0x100, s_ack 2 cycles after s_req, s_rdata 0xDEADBEEF -> m0_ack one cycle, m0_rdata 0xDEADBEEF, m0_err 0, m1_ack 0.
REQ-033 m0 and m1 request together after reset -> m0 served first, then m1; repeat -> order alternates.
REQ-034 m1 store addr 0x200 wdata 0x12345678 mode SW, no s_ack -> s_req low after TIMEOUT=15 WAIT cycles, m1_ack, m1_err 1, m1_rdata 0.
REQ-035 s_ack in the cycle count reaches TIMEOUT -> err 0, rdata captured.
REQ-036 Reset pulsed mid-WAIT -> next cycle IDLE, s_req 0, no ack ever issued for aborted access.
REQ-037 m1 raises req while m0 in WAIT -> m1 granted in IDLE after m0's RESP, s_addr stable throughout.
